instruction_fetch: RTL and testbench

Fetch stage directly upstream of the instruction decoder. Holds the PC, issues word requests to instruction memory over a req/ack handshake, and presents one 32-bit instruction plus its PC to the decoder under a valid/ready handshake. Accepts branch redirects from the execute stage, computes the ARM-style branch target from the 24-bit word offset, and discards any fetch in flight when a redirect arrives.

---
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem req/ack, decoder valid/ready, and redirects to ARM-style branch targets.
// Optional BL link-register write is enabled by defining LINK_EN.
module instruction_fetch #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction_set,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              dec_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [23:0]       br_address,
  input  logic              br_link,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] BR_BIAS    = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_drain_addr;
  logic [31:0]         r_instr;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_instr_pc;

  logic signed [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0]        w_target_raw;
  logic [ADDR_W-1:0]        w_target;

  // Branch offset is a signed word count; the +8 models the ARM pipeline PC bias.
  assign w_br_off     = {{(ADDR_W-26){br_address[23]}}, br_address, 2'b00};
  assign w_target_raw = br_pc + BR_BIAS + $unsigned(w_br_off);
  assign w_target     = w_target_raw & ALIGN_MASK;

  assign imem_req        = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr       = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign instruction_set = r_instr;
  assign instr_valid     = r_valid;
  assign instr_pc        = r_instr_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_instr      <= '0;
      r_valid      <= 1'b0;
      r_instr_pc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (br_taken) begin
            r_pc <= w_target;
            // Unacknowledged request must complete at its old address before refetching.
            if (!imem_ack) begin
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + PC_STEP;
            r_state    <= S_HOLD;
          end
        end
        S_DRAIN: begin
          if (br_taken) r_pc <= w_target;
          if (imem_ack) r_state <= S_FETCH;
        end
        S_HOLD: begin
          if (br_taken) begin
            r_valid <= 1'b0;
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (dec_ready) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LINK_EN
  logic              r_link_we;
  logic [ADDR_W-1:0] r_link_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_link_we   <= 1'b0;
      r_link_data <= '0;
    end else begin
      r_link_we <= br_taken & br_link;
      if (br_taken && br_link) r_link_data <= br_pc + PC_STEP;
    end
  end

  assign link_we   = r_link_we;
  assign link_data = r_link_data;
`else
  logic w_unused_br_link;

  assign w_unused_br_link = br_link;
  assign link_we          = 1'b0;
  assign link_data        = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fetch flow, redirects, drain, reset, link write.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_set;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [23:0] br_address;
  logic        br_link;
  logic        link_we;
  logic [31:0] link_data;

  int passed = 0;
  int total  = 0;

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction_set(instruction_set), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .br_taken(br_taken), .br_pc(br_pc), .br_address(br_address),
    .br_link(br_link), .link_we(link_we), .link_data(link_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    br_taken = 1'b0; br_pc = '0; br_address = '0; br_link = 1'b0;
    tick(); tick();
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else passed++;
    total++; if (instruction_set !== 32'h0) $display("FAIL rst_instr: got %h want 0", instruction_set); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", instr_pc); else passed++;
    total++; if (link_we !== 1'b0 || link_data !== 32'h0) $display("FAIL rst_link: got %b/%h want 0/0", link_we, link_data); else passed++;
    reset_n = 1'b1;
    total++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req); else passed++;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req: got %b/%h want 1/00000000", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_fetch();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hE0875006;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    total++; if (instr_valid !== 1'b1) $display("FAIL f0_valid: got %b want 1", instr_valid); else passed++;
    total++; if (instruction_set !== 32'hE0875006) $display("FAIL f0_instr: got %h want e0875006", instruction_set); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL f0_pc: got %h want 0", instr_pc); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL f0_req_hold: got %b want 0", imem_req); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instruction_set !== 32'hE0875006 || imem_req !== 1'b0)
        $display("FAIL hold_stable%0d: got %b/%h/%b want 1/e0875006/0", i, instr_valid, instruction_set, imem_req);
      else passed++;
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL f0_consumed: got %b want 0", instr_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL f1_addr: got %b/%h want 1/00000004", imem_req, imem_addr); else passed++;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hE3A01001;
    tick();
    imem_ack = 1'b0;
    total++; if (instr_pc !== 32'h4 || instruction_set !== 32'hE3A01001) $display("FAIL f1_out: got %h/%h want 00000004/e3a01001", instr_pc, instruction_set); else passed++;
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    total++; if (imem_addr !== 32'h8) $display("FAIL f2_addr: got %h want 00000008", imem_addr); else passed++;
  endtask

  task automatic test_branch_hold();
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    tick();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) $display("FAIL bh_pre: got %b/%h want 1/00000008", instr_valid, instr_pc); else passed++;
    br_taken = 1'b1; br_pc = 32'h100; br_address = 24'h000002; dec_ready = 1'b1;
    tick();
    br_taken = 1'b0; dec_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL bh_valid: got %b want 0", instr_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) $display("FAIL bh_target: got %b/%h want 1/00000110", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_target_calc();
    br_taken = 1'b1; br_pc = 32'h20; br_address = 24'hFFFFFC;
    tick();
    br_taken = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) $display("FAIL back_drain_addr: got %b/%h want 1/00000110", imem_req, imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 32'h18 || instr_valid !== 1'b0) $display("FAIL back_target: got %h/%b want 00000018/0", imem_addr, instr_valid); else passed++;
    br_taken = 1'b1; br_pc = 32'hFFFFFFF8; br_address = 24'h0; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    br_taken = 1'b0; imem_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) $display("FAIL wrap_target: got %b/%h/%b want 1/00000000/0", imem_req, imem_addr, instr_valid); else passed++;
  endtask

  task automatic test_drain();
    br_taken = 1'b1; br_pc = 32'h200; br_address = 24'h0;
    tick();
    br_taken = 1'b0;
    tick(); tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL drain_hold_addr: got %b/%h want 1/00000000", imem_req, imem_addr); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'hBADBADBA;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 32'h208 || instr_valid !== 1'b0) $display("FAIL drain_target: got %h/%b want 00000208/0", imem_addr, instr_valid); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'h11111111;
    tick();
    imem_ack = 1'b0;
    total++; if (instruction_set !== 32'h11111111 || instr_pc !== 32'h208) $display("FAIL drain_next_instr: got %h/%h want 11111111/00000208", instruction_set, instr_pc); else passed++;
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    br_taken = 1'b1; br_pc = 32'h300; br_address = 24'h0;
    tick();
    br_pc = 32'h400; br_address = 24'h000001;
    tick();
    total++; if (imem_addr !== 32'h20C) $display("FAIL drain2_old_addr: got %h want 0000020c", imem_addr); else passed++;
    br_pc = 32'h500; br_address = 24'h0; imem_ack = 1'b1; imem_rdata = 32'hBADBADBA;
    tick();
    br_taken = 1'b0; imem_ack = 1'b0;
    total++; if (imem_addr !== 32'h508 || instr_valid !== 1'b0) $display("FAIL drain2_newest: got %h/%b want 00000508/0", imem_addr, instr_valid); else passed++;
    total++; if (instruction_set !== 32'h11111111) $display("FAIL drain_no_leak: got %h want 11111111", instruction_set); else passed++;
  endtask

  task automatic test_reset_midflight();
    reset_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL mid_rst_ctl: got %b/%b want 0/0", imem_req, instr_valid); else passed++;
    total++; if (instruction_set !== 32'h0 || instr_pc !== 32'h0) $display("FAIL mid_rst_data: got %h/%h want 0/0", instruction_set, instr_pc); else passed++;
    imem_ack = 1'b1; imem_rdata = 32'hCAFECAFE;
    tick();
    imem_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) $display("FAIL post_rst_fetch: got %b/%h/%b want 1/00000000/0", imem_req, imem_addr, instr_valid); else passed++;
  endtask

  task automatic test_link();
    br_taken = 1'b1; br_link = 1'b1; br_pc = 32'h40; br_address = 24'h0;
    tick();
    br_taken = 1'b0;
`ifdef LINK_EN
    total++; if (link_we !== 1'b1 || link_data !== 32'h44) $display("FAIL link_pulse: got %b/%h want 1/00000044", link_we, link_data); else passed++;
`else
    total++; if (link_we !== 1'b0 || link_data !== 32'h0) $display("FAIL link_off: got %b/%h want 0/0", link_we, link_data); else passed++;
`endif
    tick();
    total++; if (link_we !== 1'b0) $display("FAIL link_one_cycle: got %b want 0", link_we); else passed++;
    br_link = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 32'h48 || link_we !== 1'b0) $display("FAIL link_target: got %h/%b want 00000048/0", imem_addr, link_we); else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch_hold();
    test_target_calc();
    test_drain();
    test_reset_midflight();
    test_link();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
